mem_req_arbiter: RTL



---
 rtl/mem_req_arbiter_pkg.sv | 25 ++
 rtl/mem_req_arbiter_if.sv | 45 ++++
 rtl/mem_req_arbiter_picker.sv | 33 +++
 rtl/mem_req_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the line-miss arbiter: requester ids, arbiter state,
// line geometry and a small grant helper.
package rv32i_types;

  localparam int LINE_BYTES = 32;
  localparam int OFFSET_W   = $clog2(LINE_BYTES);

  // Which requester currently owns the adapter.
  typedef enum logic [1:0] {
    inst_t = 2'b00,
    data_t = 2'b01,
    pref_t = 2'b10
  } servicing_t;

  typedef enum logic {
    arb_idle_s,
    arb_busy_s
  } arb_state_t;

  // Only demand grants take part in the round-robin history.
  function automatic logic is_demand(servicing_t s);
    return (s != pref_t);
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundle of the three requester ports plus the adapter (DFP) port.
// slave = arbiter view, master = the caches/prefetcher/adapter side.
interface mem_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  // icache
  logic [ADDR_W-1:0] i_addr;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  // dcache
  logic [ADDR_W-1:0] d_addr;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  // prefetcher
  logic [ADDR_W-1:0] p_addr;
  logic              p_read;
  logic [LINE_W-1:0] p_rdata;
  logic              p_resp;
  // burst adapter
  logic [ADDR_W-1:0] dfp_addr;
  logic              dfp_read;
  logic              dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic [LINE_W-1:0] dfp_rdata;
  logic              dfp_resp;

  modport slave (
    input  i_addr, i_read, d_addr, d_read, d_write, d_wdata,
           p_addr, p_read, dfp_rdata, dfp_resp,
    output i_rdata, i_resp, d_rdata, d_resp, p_rdata, p_resp,
           dfp_addr, dfp_read, dfp_write, dfp_wdata
  );

  modport master (
    output i_addr, i_read, d_addr, d_read, d_write, d_wdata,
           p_addr, p_read, dfp_rdata, dfp_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, p_rdata, p_resp,
           dfp_addr, dfp_read, dfp_write, dfp_wdata
  );
endinterface

// File: rtl/mem_req_arbiter_picker.sv
// Combinational grant choice: demand before prefetch, demand ties go to
// the port that was not served last.
module mem_grant_picker
  import rv32i_types::*;
(
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  logic       p_req_i,
  input  servicing_t last_demand_i,
  output servicing_t grant_o,
  output logic       valid_o
);

  // Priority pick; prefetch only sees bandwidth no demand port wants.
  always_comb begin
    grant_o = inst_t;
    valid_o = 1'b0;
    if (i_req_i && d_req_i) begin
      valid_o = 1'b1;
      grant_o = (last_demand_i == inst_t) ? data_t : inst_t;
    end else if (i_req_i) begin
      valid_o = 1'b1;
      grant_o = inst_t;
    end else if (d_req_i) begin
      valid_o = 1'b1;
      grant_o = data_t;
    end else if (p_req_i) begin
      valid_o = 1'b1;
      grant_o = pref_t;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Serialises icache / dcache / prefetch line transactions onto the single
// burst adapter, one line at a time.
module mem_req_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic             clk,
  input  logic             rst,
  mem_req_arbiter_if.slave bus
);

  arb_state_t state_q, state_d;
  servicing_t grant_q, grant_d;
  servicing_t last_demand_q, last_demand_d;

  servicing_t pick_grant;
  logic       pick_valid;
  logic       granted_req;
  logic [ADDR_W-1:0] sel_addr;

  mem_grant_picker u_picker (
    .i_req_i       (bus.i_read),
    .d_req_i       (bus.d_read | bus.d_write),
    .p_req_i       (bus.p_read),
    .last_demand_i (last_demand_q),
    .grant_o       (pick_grant),
    .valid_o       (pick_valid)
  );

  // Next-state: grant only from IDLE, so every resp is followed by at
  // least one IDLE cycle and the served requester has dropped by then.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_demand_d = last_demand_q;
    case (state_q)
      arb_idle_s: begin
        if (pick_valid) begin
          state_d = arb_busy_s;
          grant_d = pick_grant;
          if (is_demand(pick_grant)) last_demand_d = pick_grant;
        end
      end
      arb_busy_s: begin
        if (bus.dfp_resp) state_d = arb_idle_s;
      end
      default: state_d = arb_idle_s;
    endcase
  end

  // State registers; async reset abandons any in-flight line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= arb_idle_s;
      grant_q       <= inst_t;
      last_demand_q <= inst_t;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_demand_q <= last_demand_d;
    end
  end

  // Address and live request of whichever port holds the grant.
  always_comb begin
    case (grant_q)
      inst_t:  begin sel_addr = bus.i_addr; granted_req = bus.i_read; end
      data_t:  begin sel_addr = bus.d_addr; granted_req = bus.d_read | bus.d_write; end
      default: begin sel_addr = bus.p_addr; granted_req = bus.p_read; end
    endcase
  end

  // Adapter drive and resp routing; everything is quiet outside BUSY.
  always_comb begin
    bus.dfp_addr  = '0;
    bus.dfp_read  = 1'b0;
    bus.dfp_write = 1'b0;
    bus.dfp_wdata = '0;
    bus.i_resp    = 1'b0;
    bus.d_resp    = 1'b0;
    bus.p_resp    = 1'b0;
    if (state_q == arb_busy_s) begin
      bus.dfp_addr = {sel_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
      case (grant_q)
        data_t: begin
          bus.dfp_read  = bus.d_read;
          bus.dfp_write = bus.d_write;
          bus.dfp_wdata = bus.d_write ? bus.d_wdata : '0;
          bus.d_resp    = bus.dfp_resp;
        end
        inst_t: begin
          bus.dfp_read = 1'b1;
          bus.i_resp   = bus.dfp_resp;
        end
        default: begin
          bus.dfp_read = 1'b1;
          bus.p_resp   = bus.dfp_resp;
        end
      endcase
    end
  end

  // Read data fans out unqualified; resp is the only qualifier.
  assign bus.i_rdata = bus.dfp_rdata;
  assign bus.d_rdata = bus.dfp_rdata;
  assign bus.p_rdata = bus.dfp_rdata;

  // Adapter must not respond while nothing is outstanding.
  a_resp_in_idle: assert property (@(posedge clk) disable iff (rst)
    !(state_q == arb_idle_s && bus.dfp_resp));

  // Granted requester must hold its request until the resp.
  a_req_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == arb_busy_s && !bus.dfp_resp) |-> granted_req);

  // dcache never asks for read and writeback together.
  a_d_rw_excl: assert property (@(posedge clk) disable iff (rst)
    !(bus.d_read && bus.d_write));

endmodule
